// File: rtl/boreal_eeg_acq_sequencer.sv
// -----------------------------------------------------------------------------
// boreal_eeg_acq_sequencer
//
// Frame sequencer for the 8-channel EEG fusion datapath. Each sample tick
// starts a frame. The sequencer visits every channel in index order and polls
// each enabled channel through a req/ack handshake with the ADC front-end. It
// assembles the raw sample array and emits a single data_valid strobe per frame.
// Channels that do not answer within TIMEOUT_CYC request cycles are abandoned
// and flagged. Ticks that arrive while a frame is in flight are counted as
// overruns.
//
// Parameters
//   NUM_CH       channel count (power of two)
//   DATA_W       ADC sample width
//   TIMEOUT_CYC  request cycles allowed before a channel is abandoned (>= 2)
//   OVR_W        width of the saturating overrun counter
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-high reset
//   sample_tick    in   1-cycle frame-start pulse
//   ch_enable      in   per-channel enable, captured at frame start
//   clear_status   in   1-cycle pulse clearing timeout_flags / overrun_count
//   adc_req        out  conversion request (registered)
//   adc_ch         out  channel index of the current request (registered)
//   adc_ack        in   ADC result valid, qualified by adc_req
//   adc_data       in   ADC result, captured in the ack cycle
//   raw_eeg_array  out  channel k at [k*DATA_W +: DATA_W]
//   data_valid     out  1-cycle strobe: raw_eeg_array holds a new frame
//   frame_busy     out  high whenever the sequencer is not idle
//   timeout_flags  out  sticky per-channel timeout indicators
//   overrun_count  out  saturating count of dropped sample ticks
// -----------------------------------------------------------------------------
module boreal_eeg_acq_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 64,
  parameter int OVR_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     clear_status,
  output logic                     adc_req,
  output logic [$clog2(NUM_CH)-1:0] adc_ch,
  input  logic                     adc_ack,
  input  logic [DATA_W-1:0]        adc_data,
  output logic [NUM_CH*DATA_W-1:0] raw_eeg_array,
  output logic                     data_valid,
  output logic                     frame_busy,
  output logic [NUM_CH-1:0]        timeout_flags,
  output logic [OVR_W-1:0]         overrun_count
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int ARR_W = NUM_CH * DATA_W;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CH_W-1:0]    ch_idx, ch_idx_d;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_d;
  logic [NUM_CH-1:0]  en_snap, en_snap_d;
  logic [ARR_W-1:0]   shadow, shadow_d;
  logic [NUM_CH-1:0]  tmo_set;
  logic               ack_q;
  logic               overrun;

  // adc_req is high exactly while in REQ, so this is the qualified ack.
  assign ack_q      = adc_ack && (state == REQ);
  assign overrun    = sample_tick && (state != IDLE);
  assign frame_busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    ch_idx_d  = ch_idx;
    tmo_cnt_d = tmo_cnt;
    en_snap_d = en_snap;
    shadow_d  = shadow;
    tmo_set   = '0;

    unique case (state)
      IDLE: begin
        if (sample_tick) begin
          en_snap_d = ch_enable;
          ch_idx_d  = '0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (en_snap[ch_idx]) begin
          tmo_cnt_d = '0;
          state_d   = REQ;
        end else begin
          shadow_d[ch_idx*DATA_W +: DATA_W] = '0;
          if (ch_idx == LAST_CH) begin
            state_d = EMIT;
          end else begin
            ch_idx_d = ch_idx + 1'b1;
            state_d  = SCAN;
          end
        end
      end

      REQ: begin
        if (ack_q || (tmo_cnt == TMO_LAST)) begin
          // Ack has priority over a timeout landing in the same cycle. On a
          // timeout the shadow slot keeps the previous frame's sample.
          if (ack_q) shadow_d[ch_idx*DATA_W +: DATA_W] = adc_data;
          else       tmo_set[ch_idx] = 1'b1;
          if (ch_idx == LAST_CH) begin
            state_d = EMIT;
          end else begin
            ch_idx_d = ch_idx + 1'b1;
            state_d  = SCAN;
          end
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end

      EMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: the shadow array is reset along with the control state, because a
  // timed-out channel republishes whatever the shadow holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx        <= '0;
      tmo_cnt       <= '0;
      en_snap       <= '0;
      shadow        <= '0;
      adc_req       <= 1'b0;
      adc_ch        <= '0;
      raw_eeg_array <= '0;
      data_valid    <= 1'b0;
      timeout_flags <= '0;
      overrun_count <= '0;
    end else begin
      ch_idx  <= ch_idx_d;
      tmo_cnt <= tmo_cnt_d;
      en_snap <= en_snap_d;
      shadow  <= shadow_d;

      // Request outputs are registered from the next state, so they are
      // stable for the whole REQ residency and drop on the exit edge.
      adc_req <= (state_d == REQ);
      adc_ch  <= (state_d == REQ) ? ch_idx_d : '0;

      // The last channel's sample lands on the same edge that enters EMIT,
      // so the published array comes from the next-shadow value.
      data_valid <= (state_d == EMIT);
      if (state_d == EMIT) raw_eeg_array <= shadow_d;

      // A clear takes effect first; same-cycle events are then applied on top.
      timeout_flags <= (clear_status ? '0 : timeout_flags) | tmo_set;

      if (clear_status) begin
        overrun_count <= overrun ? OVR_W'(1) : '0;
      end else if (overrun && (overrun_count != '1)) begin
        overrun_count <= overrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boreal_eeg_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_boreal_eeg_acq_sequencer
//
// Self-checking bench. An ADC responder answers each request after a
// per-channel latency (or never). A frame-level reference model predicts the
// frame timing, the published array, the sticky flags and the overrun count
// from the channel mask and the latencies.
// -----------------------------------------------------------------------------
module tb_boreal_eeg_acq_sequencer;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 24;
  localparam int TMO    = 64;
  localparam int ARR_W  = NUM_CH * DATA_W;

  typedef logic [ARR_W-1:0] wide_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_tick;
  logic [7:0]        ch_enable;
  logic              clear_status;
  logic              adc_req;
  logic [2:0]        adc_ch;
  logic              adc_ack;
  logic [23:0]       adc_data;
  logic [ARR_W-1:0]  raw_eeg_array;
  logic              data_valid;
  logic              frame_busy;
  logic [7:0]        timeout_flags;
  logic [15:0]       overrun_count;

  boreal_eeg_acq_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .ch_enable     (ch_enable),
    .clear_status  (clear_status),
    .adc_req       (adc_req),
    .adc_ch        (adc_ch),
    .adc_ack       (adc_ack),
    .adc_data      (adc_data),
    .raw_eeg_array (raw_eeg_array),
    .data_valid    (data_valid),
    .frame_busy    (frame_busy),
    .timeout_flags (timeout_flags),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // ADC responder: acks channel c after cur_lat[c] extra cycles (-1 = never).
  // Records every request episode (channel, length in cycles).
  // ---------------------------------------------------------------------------
  int          cur_lat [NUM_CH];
  logic [23:0] cur_data[NUM_CH];
  bit          spur_ack = 1'b0;
  bit          prev_req = 1'b0;
  int          ep_ch, ep_len;
  int          ep_ch_q[$];
  int          ep_len_q[$];
  int          hs_cnt = 0;
  int          ch_unstable = 0;

  initial begin
    adc_ack  = 1'b0;
    adc_data = '0;
  end

  always @(posedge clk) begin
    #2;
    if (adc_req === 1'b1) begin
      if (!prev_req) begin
        ep_ch  = int'(adc_ch);
        ep_len = 0;
      end else if (int'(adc_ch) != ep_ch) begin
        ch_unstable++;
      end
      adc_ack = (cur_lat[adc_ch] >= 0) && (ep_len == cur_lat[adc_ch]);
      ep_len++;
      if (adc_ack) hs_cnt++;
    end else begin
      if (prev_req) begin
        ep_ch_q.push_back(ep_ch);
        ep_len_q.push_back(ep_len);
      end
      adc_ack = spur_ack;
    end
    prev_req = (adc_req === 1'b1);
    adc_data = cur_data[adc_ch];
  end

  // ---------------------------------------------------------------------------
  // Reference model state (what the outputs should hold between frames)
  // ---------------------------------------------------------------------------
  wide_t      m_arr   = '0;
  logic [7:0] m_flags = '0;
  int         m_cnt   = 0;

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Run one frame from IDLE. Ticks are injected at cycles 1,3,5,.. (n_ovr of
  // them) and optionally in the EMIT cycle; clear_status is pulsed at
  // clear_cyc (-1 = never). Cycle 1 is the first cycle after the tick edge.
  task automatic run_frame(input logic [7:0] mask, input int n_ovr,
                           input bit emit_tick, input int clear_cyc,
                           input string tag, output int o_dv, output int o_hs);
    int         t;
    int         exp_dv;
    int         exp_hs;
    int         tmo_cyc[NUM_CH];
    logic [7:0] tmo_set;
    int         ticks[$];
    int         exp_ch_q[$];
    int         exp_len_q[$];
    wide_t      exp_arr;
    logic [7:0] exp_flags;
    int         exp_cnt;
    int         n_after;
    int         cyc;
    int         dv_at;
    int         dv_n;

    // --- reference model: walk the channels in order with per-channel cost
    exp_arr = m_arr;
    tmo_set = '0;
    exp_hs  = 0;
    t       = 1;
    for (int k = 0; k < NUM_CH; k++) begin
      tmo_cyc[k] = 0;
      if (!mask[k]) begin
        exp_arr[k*DATA_W +: DATA_W] = '0;
        t += 1;
      end else if (cur_lat[k] >= 0 && cur_lat[k] < TMO) begin
        exp_arr[k*DATA_W +: DATA_W] = cur_data[k];
        exp_ch_q.push_back(k);
        exp_len_q.push_back(cur_lat[k] + 1);
        exp_hs++;
        t += cur_lat[k] + 2;
      end else begin
        tmo_set[k] = 1'b1;
        tmo_cyc[k] = t + TMO;
        exp_ch_q.push_back(k);
        exp_len_q.push_back(TMO);
        t += TMO + 1;
      end
    end
    exp_dv = t;

    for (int i = 0; i < n_ovr; i++) ticks.push_back(1 + 2 * i);
    if (emit_tick) ticks.push_back(exp_dv);

    if (clear_cyc > 0) begin
      exp_flags = '0;
      for (int k = 0; k < NUM_CH; k++)
        if (tmo_set[k] && tmo_cyc[k] >= clear_cyc) exp_flags[k] = 1'b1;
      n_after = 0;
      foreach (ticks[i]) if (ticks[i] >= clear_cyc) n_after++;
      exp_cnt = n_after;
    end else begin
      exp_flags = m_flags | tmo_set;
      exp_cnt   = m_cnt + ticks.size();
      if (exp_cnt > 65535) exp_cnt = 65535;
    end

    // --- stimulus
    @(posedge clk); #1;
    ep_ch_q.delete();
    ep_len_q.delete();
    hs_cnt      = 0;
    ch_unstable = 0;
    ch_enable   = mask;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    ch_enable   = ~mask;      // must not affect the frame in flight
    cyc   = 1;
    dv_at = -1;
    dv_n  = 0;
    check($sformatf("%s busy_after_tick", tag), wide_t'(frame_busy), wide_t'(1));
    while (1) begin
      if (data_valid === 1'b1) begin
        dv_n++;
        if (dv_at < 0) dv_at = cyc;
      end
      if ((dv_at >= 0 && cyc >= dv_at + 2) || cyc >= exp_dv + 300) break;
      sample_tick  = in_q(ticks, cyc);
      clear_status = (cyc == clear_cyc);
      @(posedge clk); #1;
      sample_tick  = 1'b0;
      clear_status = 1'b0;
      cyc++;
    end

    // --- comparisons
    check($sformatf("%s dv_cycle", tag), wide_t'(dv_at), wide_t'(exp_dv));
    check($sformatf("%s dv_pulses", tag), wide_t'(dv_n), wide_t'(1));
    check($sformatf("%s array", tag), raw_eeg_array, exp_arr);
    check($sformatf("%s flags", tag), wide_t'(timeout_flags), wide_t'(exp_flags));
    check($sformatf("%s overruns", tag), wide_t'(overrun_count), wide_t'(exp_cnt));
    check($sformatf("%s handshakes", tag), wide_t'(hs_cnt), wide_t'(exp_hs));
    check($sformatf("%s req_episodes", tag), wide_t'(ep_ch_q.size()), wide_t'(exp_ch_q.size()));
    for (int i = 0; i < exp_ch_q.size() && i < ep_ch_q.size(); i++) begin
      check($sformatf("%s ep%0d_ch", tag, i), wide_t'(ep_ch_q[i]), wide_t'(exp_ch_q[i]));
      check($sformatf("%s ep%0d_len", tag, i), wide_t'(ep_len_q[i]), wide_t'(exp_len_q[i]));
    end
    check($sformatf("%s adc_ch_stable", tag), wide_t'(ch_unstable), wide_t'(0));
    check($sformatf("%s idle_after", tag), wide_t'(frame_busy), wide_t'(0));

    m_arr   = exp_arr;
    m_flags = exp_flags;
    m_cnt   = exp_cnt;
    o_dv    = dv_at;
    o_hs    = hs_cnt;
  endtask

  task automatic set_uniform(input int lat, input int dead, input int seed);
    for (int k = 0; k < NUM_CH; k++) begin
      cur_lat[k]  = (k == dead) ? -1 : lat;
      cur_data[k] = 24'h100000 + 24'(k) + 24'(seed * 16);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] mask;
    int         lat;
    int         dead;
    int         exp_dv;
    int         exp_hs;
    logic [7:0] exp_flags;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int o_dv, o_hs;
    int found;
    int bad;

    vecs[0] = '{8'hFF,  1, -1, 25, 8, 8'h00};  // all enabled, ack after 1 cycle
    vecs[1] = '{8'hA5,  1, -1, 17, 4, 8'h00};  // sparse mask
    vecs[2] = '{8'h00,  1, -1,  9, 0, 8'h00};  // nothing enabled
    vecs[3] = '{8'hFF,  0, -1, 17, 8, 8'h00};  // same-cycle ack
    vecs[4] = '{8'hFF,  1,  3, 87, 7, 8'h08};  // ch3 never answers
    vecs[5] = '{8'h01, 63, -1, 73, 1, 8'h08};  // ack on the last allowed cycle
    vecs[6] = '{8'h01, 64, -1, 73, 0, 8'h09};  // ack one cycle too late

    rst          = 1'b1;
    sample_tick  = 1'b0;
    ch_enable    = '0;
    clear_status = 1'b0;
    set_uniform(1, -1, 0);

    // --- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst adc_req", wide_t'(adc_req), wide_t'(0));
    check("rst adc_ch", wide_t'(adc_ch), wide_t'(0));
    check("rst data_valid", wide_t'(data_valid), wide_t'(0));
    check("rst frame_busy", wide_t'(frame_busy), wide_t'(0));
    check("rst array", raw_eeg_array, wide_t'(0));
    check("rst flags", wide_t'(timeout_flags), wide_t'(0));
    check("rst overruns", wide_t'(overrun_count), wide_t'(0));
    rst = 1'b0;

    // --- table-driven frames
    for (int r = 0; r < 7; r++) begin
      set_uniform(vecs[r].lat, vecs[r].dead, r);
      run_frame(vecs[r].mask, 0, 1'b0, -1, $sformatf("vec%0d", r), o_dv, o_hs);
      check($sformatf("vec%0d tbl_dv", r), wide_t'(o_dv), wide_t'(vecs[r].exp_dv));
      check($sformatf("vec%0d tbl_hs", r), wide_t'(o_hs), wide_t'(vecs[r].exp_hs));
      check($sformatf("vec%0d tbl_flags", r), wide_t'(timeout_flags), wide_t'(vecs[r].exp_flags));
    end

    // --- clear coincident with a ch6 timeout (ch6 REQ spans cycles 8..71)
    set_uniform(1, 6, 9);
    run_frame(8'h40, 0, 1'b0, 71, "clr_tmo", o_dv, o_hs);
    check("clr_tmo flags_only_ch6", wide_t'(timeout_flags), wide_t'(8'h40));

    // --- spurious acks outside REQ are ignored
    spur_ack = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (frame_busy !== 1'b0 || adc_req !== 1'b0 || data_valid !== 1'b0) bad++;
    end
    check("spur idle_undisturbed", wide_t'(bad), wide_t'(0));
    set_uniform(1, -1, 10);
    run_frame(8'hA5, 0, 1'b0, -1, "spur_scan", o_dv, o_hs);
    spur_ack = 1'b0;

    // --- reset while requesting ch5
    set_uniform(1, -1, 11);
    @(posedge clk); #1;
    ch_enable   = 8'hFF;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (adc_req === 1'b1 && adc_ch == 3'd5) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("rst_mid reached_ch5", wide_t'(found), wide_t'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_mid adc_req", wide_t'(adc_req), wide_t'(0));
    check("rst_mid busy", wide_t'(frame_busy), wide_t'(0));
    check("rst_mid outputs", {raw_eeg_array, timeout_flags, overrun_count, adc_ch, data_valid},
          wide_t'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (data_valid !== 1'b0 || frame_busy !== 1'b0) bad++;
    end
    check("rst_mid no_dv", wide_t'(bad), wide_t'(0));
    m_arr   = '0;
    m_flags = '0;
    m_cnt   = 0;
    run_frame(8'hFF, 0, 1'b0, -1, "post_rst", o_dv, o_hs);

    // --- overruns: three dropped ticks, then a clear with a 4th tick
    set_uniform(1, -1, 12);
    run_frame(8'hFF, 3, 1'b0, -1, "ovr3", o_dv, o_hs);
    check("ovr3 count", wide_t'(overrun_count), wide_t'(3));
    run_frame(8'hFF, 1, 1'b0, 1, "ovr_clr", o_dv, o_hs);
    check("ovr_clr count", wide_t'(overrun_count), wide_t'(1));
    run_frame(8'h3C, 0, 1'b1, -1, "ovr_emit", o_dv, o_hs);
    check("ovr_emit count", wide_t'(overrun_count), wide_t'(2));

    // --- randomized frames against the model
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cur_lat[k]  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
        cur_data[k] = 24'($urandom);
      end
      run_frame(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1,
                $sformatf("rnd%0d", f), o_dv, o_hs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
